alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu.sv | 44 ++++
 rtl/alu_arbiter.sv | 144 ++++++++++++++
 tb/tb_alu_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU arbiter slice.
//   - ALU control-code constants (AND, OR, ADD, SUB, SLT)
//   - FSM state enum used by the arbiter
//   - usesSubtract(): tells whether a control code routes B through the
//     inverter so the single adder computes A - B
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // SUB and SLT both need A - B from the one shared adder.
    function automatic logic usesSubtract(input logic [2:0] code);
        return (code == ALU_SUB) || (code == ALU_SLT);
    endfunction

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Combinational 32-bit ALU with a single adder shared by ADD, SUB and SLT.
// Ports:
//   srca, srcb  : 32-bit operands
//   alucontrol  : 3-bit control code (see alu_pkg)
//   aluout      : 32-bit result, modulo 2^32
//   zero        : high when aluout is zero
// Codes without an operation (011, 100, 101) pass srca through unchanged.
// ---------------------------------------------------------------------------
module alu (
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic [2:0]  alucontrol,
    output logic [31:0] aluout,
    output logic        zero
);
    import alu_pkg::*;

    logic        w_sub;
    logic [31:0] w_bOperand;
    logic [31:0] w_sum;

    // Two's-complement subtract: A + ~B + 1 through the same adder.
    assign w_sub      = usesSubtract(alucontrol);
    assign w_bOperand = w_sub ? ~srcb : srcb;
    assign w_sum      = srca + w_bOperand + {31'b0, w_sub};

    // SLT takes the sign of the difference directly, without overflow correction.
    always_comb begin
        aluout = srca;
        case (alucontrol)
            ALU_AND: aluout = srca & srcb;
            ALU_OR:  aluout = srca | srcb;
            ALU_ADD: aluout = w_sum;
            ALU_SUB: aluout = w_sum;
            ALU_SLT: aluout = {31'b0, w_sum[31]};
            default: aluout = srca;
        endcase
    end

    assign zero = (aluout == 32'd0);

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Round-robin arbiter sharing one ALU among NREQ requesters, one operation
// in flight at a time (IDLE -> EXEC -> RESP -> IDLE).
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   req_valid/ready    : per-requester operation handshake (ready is
//                        combinational, only in IDLE)
//   req_srca/srcb/ctrl : per-requester operands and control code
//   rsp_valid/ready    : per-requester response handshake
//   rsp_aluout/zero    : registered shared result and zero flag
//   busy               : high whenever the FSM is not in IDLE
//   op_count           : completed responses since reset (wraps)
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int NREQ = 2,
    parameter int CNTW = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][31:0] req_srca,
    input  logic [NREQ-1:0][31:0] req_srcb,
    input  logic [NREQ-1:0][2:0]  req_ctrl,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [31:0]           rsp_aluout,
    output logic                  rsp_zero,
    output logic                  busy,
    output logic [CNTW-1:0]       op_count
);
    import alu_pkg::*;

    localparam int            GW         = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [GW-1:0] LAST_RESET = GW'(NREQ - 1);

    state_t          r_state;
    logic [GW-1:0]   r_lastGrant;
    logic [GW-1:0]   r_grant;
    logic [31:0]     r_srca;
    logic [31:0]     r_srcb;
    logic [2:0]      r_ctrl;
    logic [31:0]     r_aluout;
    logic            r_zero;
    logic [CNTW-1:0] r_opCount;
    logic [NREQ-1:0] r_rspValid;
    logic            r_busy;

    logic            w_grantFound;
    logic [GW-1:0]   w_grantIdx;
    logic [NREQ-1:0] w_respOneHot;
    logic [31:0]     w_aluout;
    logic            w_zero;

    // Round-robin search starting one past the last served requester.
    // The inner loop keeps every select index constant after unrolling.
    always_comb begin
        w_grantFound = 1'b0;
        w_grantIdx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!w_grantFound && req_valid[i] &&
                    (i == ((int'(r_lastGrant) + k) % NREQ))) begin
                    w_grantFound = 1'b1;
                    w_grantIdx   = GW'(i);
                end
            end
        end
    end

    // req_ready is gated by rst_n so it stays low while reset is held.
    always_comb begin
        req_ready    = '0;
        w_respOneHot = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i]    = rst_n && (r_state == ST_IDLE) && w_grantFound &&
                              (w_grantIdx == GW'(i));
            w_respOneHot[i] = (r_grant == GW'(i));
        end
    end

    alu u_alu (
        .srca       (r_srca),
        .srcb       (r_srcb),
        .alucontrol (r_ctrl),
        .aluout     (w_aluout),
        .zero       (w_zero)
    );

    // Single FSM block; busy and rsp_valid are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_lastGrant <= LAST_RESET;
            r_grant     <= '0;
            r_srca      <= '0;
            r_srcb      <= '0;
            r_ctrl      <= '0;
            r_aluout    <= '0;
            r_zero      <= 1'b0;
            r_opCount   <= '0;
            r_rspValid  <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grantFound) begin
                        r_srca  <= req_srca[w_grantIdx];
                        r_srcb  <= req_srcb[w_grantIdx];
                        r_ctrl  <= req_ctrl[w_grantIdx];
                        r_grant <= w_grantIdx;
                        r_busy  <= 1'b1;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_aluout   <= w_aluout;
                    r_zero     <= w_zero;
                    r_rspValid <= w_respOneHot;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    // Only the granted requester's rsp_ready can end the response.
                    if (rsp_ready[r_grant]) begin
                        r_lastGrant <= r_grant;
                        r_opCount   <= r_opCount + CNTW'(1);
                        r_rspValid  <= '0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid  = r_rspValid;
    assign rsp_aluout = r_aluout;
    assign rsp_zero   = r_zero;
    assign busy       = r_busy;
    assign op_count   = r_opCount;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Scoreboard bench for alu_arbiter: the stimulus side predicts the grant and
// result of each accepted operation and queues it; a negedge monitor pops
// and compares whenever a response appears, and tracks it to its handshake.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int NREQ = 3;
    localparam int CNTW = 16;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       pend = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][31:0] opA = '0;
    logic [NREQ-1:0][31:0] opB = '0;
    logic [NREQ-1:0][2:0]  opC = '0;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready = '0;
    logic [31:0]           rsp_aluout;
    logic                  rsp_zero;
    logic                  busy;
    logic [CNTW-1:0]       op_count;

    alu_arbiter #(.NREQ(NREQ), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (pend),
        .req_ready  (req_ready),
        .req_srca   (opA),
        .req_srcb   (opB),
        .req_ctrl   (opC),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_aluout (rsp_aluout),
        .rsp_zero   (rsp_zero),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        int          g;
        logic [31:0] res;
        logic        z;
        int          cyc;
    } exp_t;

    exp_t            sbq[$];
    exp_t            cur;
    bit              active = 1'b0;
    bit              hsPrev = 1'b0;
    int              mCount = 0;
    int              mLast = NREQ - 1;
    int              nChecks = 0;
    int              nFails = 0;
    int              rspMode = 1;
    logic [NREQ-1:0] rspForce = '0;

    // Reference ALU straight from the control-code table.
    function automatic logic [31:0] refAlu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] c);
        logic [31:0] d;
        d = a - b;
        case (c)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return d;
            3'b111:  return d[31] ? 32'd1 : 32'd0;
            default: return a;
        endcase
    endfunction

    function automatic int predictGrant(input logic [NREQ-1:0] p, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (p[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] oneHot(input int g);
        logic [NREQ-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic applyStimulus(input int r, input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] c);
        opA[r]  = a;
        opB[r]  = b;
        opC[r]  = c;
        pend[r] = 1'b1;
    endtask

    task automatic applyRandom(input int r);
        logic [31:0] a;
        logic [31:0] b;
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        applyStimulus(r, a, b, 3'($urandom_range(0, 7)));
    endtask

    // Waits for an acceptance, checks the grant against the model, queues
    // the expected response. Returns at posedge+1 with the DUT in EXEC.
    task automatic serveOne(output logic [NREQ-1:0] seen);
        int   waited;
        int   g;
        exp_t e;
        waited = 0;
        @(negedge clk);
        while (req_ready == '0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        seen = req_ready;
        if (req_ready == '0) begin
            checkOutput("accept_timeout", 64'd1, 64'd0);
            return;
        end
        g = predictGrant(pend, mLast);
        checkOutput("grant", 64'(req_ready), 64'(oneHot(g)));
        if (g < 0) return;
        e.g   = g;
        e.res = refAlu(opA[g], opB[g], opC[g]);
        e.z   = (e.res == 32'd0);
        e.cyc = cycle + 2;
        sbq.push_back(e);
        mLast = g;
        @(posedge clk);
        #1;
        pend[g] = 1'b0;
    endtask

    task automatic waitDrain();
        int w;
        w = 0;
        while ((sbq.size() != 0 || active) && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (sbq.size() != 0 || active) checkOutput("drain_timeout", 64'd1, 64'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_op_count"}, 64'(op_count), 64'd0);
        checkOutput({tag, "_aluout"}, 64'(rsp_aluout), 64'd0);
        checkOutput({tag, "_zero"}, 64'(rsp_zero), 64'd0);
    endtask

    // Response-side driver: random, all-ready or a forced pattern.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rspMode)
                0:       rsp_ready = NREQ'($urandom);
                1:       rsp_ready = '1;
                default: rsp_ready = rspForce;
            endcase
        end
    end

    // Monitor: pops on a new response, then holds it to a stable value until
    // the granted requester's handshake, after which rsp_valid must drop.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            active = 1'b0;
            hsPrev = 1'b0;
            mCount = 0;
        end else begin
            if (active) begin
                if (hsPrev) begin
                    checkOutput("rsp_valid_drop", 64'(rsp_valid), 64'd0);
                    active = 1'b0;
                end else begin
                    checkOutput("rsp_valid_hold", 64'(rsp_valid), 64'(oneHot(cur.g)));
                    checkOutput("aluout_hold", 64'(rsp_aluout), 64'(cur.res));
                    checkOutput("zero_hold", 64'(rsp_zero), 64'(cur.z));
                    checkOutput("busy_resp", 64'(busy), 64'd1);
                    checkOutput("req_ready_resp", 64'(req_ready), 64'd0);
                end
            end else if (rsp_valid != '0) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    cur    = sbq.pop_front();
                    active = 1'b1;
                    checkOutput("rsp_valid", 64'(rsp_valid), 64'(oneHot(cur.g)));
                    checkOutput("aluout", 64'(rsp_aluout), 64'(cur.res));
                    checkOutput("zero", 64'(rsp_zero), 64'(cur.z));
                    checkOutput("latency", 64'(cycle), 64'(cur.cyc));
                    checkOutput("op_count_at_rsp", 64'(op_count), 64'(mCount[CNTW-1:0]));
                end
            end
            if (active && !hsPrev && rsp_ready[cur.g]) begin
                hsPrev = 1'b1;
                mCount++;
            end else begin
                hsPrev = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NREQ-1:0] seen;
        int              w;

        // Reset: outputs idle even with a request pending.
        applyStimulus(0, 32'd1, 32'd2, 3'b010);
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        pend = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single SUB: 5 - 3 = 2.
        applyStimulus(0, 32'd5, 32'd3, 3'b110);
        serveOne(seen);
        checkOutput("single_grant", 64'(seen), 64'(3'b001));
        waitDrain();
        checkOutput("single_aluout", 64'(rsp_aluout), 64'd2);
        checkOutput("single_zero", 64'(rsp_zero), 64'd0);
        checkOutput("single_op_count", 64'(op_count), 64'd1);

        // AND with disjoint operands sets the zero flag.
        @(posedge clk);
        #1;
        applyStimulus(0, 32'h0000_00FF, 32'h0000_FF00, 3'b000);
        serveOne(seen);
        waitDrain();
        checkOutput("and_aluout", 64'(rsp_aluout), 64'd0);
        checkOutput("and_zero", 64'(rsp_zero), 64'd1);

        // SLT of -1 < 1, then ADD wrapping to zero.
        @(posedge clk);
        #1;
        applyStimulus(0, 32'hFFFF_FFFF, 32'd1, 3'b111);
        serveOne(seen);
        waitDrain();
        checkOutput("slt_aluout", 64'(rsp_aluout), 64'd1);
        @(posedge clk);
        #1;
        applyStimulus(0, 32'hFFFF_FFFF, 32'd1, 3'b010);
        serveOne(seen);
        waitDrain();
        checkOutput("wrap_aluout", 64'(rsp_aluout), 64'd0);
        checkOutput("wrap_zero", 64'(rsp_zero), 64'd1);

        // Round-robin after a fresh reset: 0,1,0,1.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        mLast = NREQ - 1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyRandom(0);
        applyRandom(1);
        for (int n = 0; n < 4; n++) begin
            serveOne(seen);
            checkOutput("rr_order", 64'(seen), 64'(oneHot(n % 2)));
            if (n < 2) applyRandom(n % 2);
        end
        waitDrain();
        checkOutput("rr_op_count", 64'(op_count), 64'd4);

        // Backpressure on requester 1 while requester 0's rsp_ready is high.
        @(posedge clk);
        #1;
        rspForce = 3'b101;
        rspMode  = 2;
        applyRandom(1);
        serveOne(seen);
        checkOutput("bp_grant", 64'(seen), 64'(3'b010));
        applyRandom(0);
        w = 0;
        while (rsp_valid == '0 && w < 10) begin
            @(negedge clk);
            w++;
        end
        checkOutput("bp_rsp_seen", 64'(rsp_valid), 64'(3'b010));
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_rsp_valid", 64'(rsp_valid), 64'(3'b010));
            checkOutput("bp_busy", 64'(busy), 64'd1);
            checkOutput("bp_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        rspMode = 1;
        serveOne(seen);
        checkOutput("bp_next_grant", 64'(seen), 64'(3'b001));
        waitDrain();

        // Reset while in EXEC abandons the operation.
        @(posedge clk);
        #1;
        applyRandom(2);
        serveOne(seen);
        rst_n = 1'b0;
        pend  = '0;
        mLast = NREQ - 1;
        @(negedge clk);
        checkResetValues("exec_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            checkOutput("post_reset_rsp_valid", 64'(rsp_valid), 64'd0);
            checkOutput("post_reset_busy", 64'(busy), 64'd0);
        end

        // Randomized traffic with random backpressure and request drops.
        @(posedge clk);
        #1;
        rspMode = 0;
        for (int n = 0; n < 40; n++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (!pend[r] && $urandom_range(0, 1) == 1) applyRandom(r);
            end
            if (pend == '0) applyRandom(int'($urandom_range(0, NREQ - 1)));
            serveOne(seen);
            for (int r = 0; r < NREQ; r++) begin
                if (pend[r] && $urandom_range(0, 7) == 0) pend[r] = 1'b0;
            end
        end
        rspMode = 1;
        waitDrain();
        checkOutput("random_op_count", 64'(op_count), 64'(mCount[CNTW-1:0]));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
